alu_issue_pipe: RTL and testbench

- Two-stage, valid/ready-handshaked front end that drives an internal alu_32 instance.
- Accepts MIPS-style ALUOp/funct plus two operands and decodes them to the 4-bit alu_control code.
- Registers the ALU result and flags and presents them downstream with backpressure.
- Sits between the decode/issue logic and writeback; it generates and consumes the alu_control interface.

---
 rtl/alu_issue_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_alu_issue_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: two-stage valid/ready front end around an alu_32 instance.
//
// S1 holds the decoded request (operands, 4-bit alu_control, illegal flag).
// S2 holds the ALU result and flags and drives the out_* interface.
// A request accepted at one clock edge reaches out_* after the next edge when
// the downstream side does not stall. Both stages move together, so the pipe
// sustains one request per cycle.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_aluop, in_funct  MIPS-style ALUOp and R-type funct field
//   in_a, in_b          32-bit operands
//   out_valid/out_ready result handshake; out_* hold stable while stalled
//   out_resultado       ALU result (0 for illegal ops)
//   out_zero/out_carry_out/out_overflow  ALU flags (all 0 for illegal ops)
//   out_illegal         request could not be decoded
//   ovf_count           saturating count of delivered results with overflow
module alu_issue_pipe #(
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_aluop,
    input  logic [5:0]           in_funct,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_resultado,
    output logic                 out_zero,
    output logic                 out_carry_out,
    output logic                 out_overflow,
    output logic                 out_illegal,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    logic [3:0]  dec_ctrl;
    logic        dec_illegal;

    logic        s1_valid;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [3:0]  s1_ctrl;
    logic        s1_illegal;

    logic        s2_load;
    logic        in_fire;

    logic [31:0] alu_resultado;
    logic        alu_zero;
    logic        alu_carry_out;
    logic        alu_overflow;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        case (in_aluop)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (in_funct)
                    6'b100000: dec_ctrl = CTRL_ADD;
                    6'b100010: dec_ctrl = CTRL_SUB;
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b100111: dec_ctrl = CTRL_NOR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // S2 accepts new contents whenever it is empty or being drained; S1
    // advances under the same condition, which is what allows a new request
    // to be accepted in the very cycle S1 hands its item to S2.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_ctrl    <= CTRL_ADD;
            s1_illegal <= 1'b0;
        end else if (in_fire) begin
            s1_valid   <= 1'b1;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_ctrl    <= dec_ctrl;
            s1_illegal <= dec_illegal;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    alu_32 u_alu (
        .a           (s1_a),
        .b           (s1_b),
        .alu_control (s1_ctrl),
        .resultado   (alu_resultado),
        .zero        (alu_zero),
        .carry_out   (alu_carry_out),
        .overflow    (alu_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_resultado <= '0;
            out_zero      <= 1'b0;
            out_carry_out <= 1'b0;
            out_overflow  <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            // Data only moves with a real item; an empty S1 leaves the last
            // result parked on the bus behind out_valid=0.
            if (s1_valid) begin
                if (s1_illegal) begin
                    out_resultado <= '0;
                    out_zero      <= 1'b0;
                    out_carry_out <= 1'b0;
                    out_overflow  <= 1'b0;
                    out_illegal   <= 1'b1;
                end else begin
                    out_resultado <= alu_resultado;
                    out_zero      <= alu_zero;
                    out_carry_out <= alu_carry_out;
                    out_overflow  <= alu_overflow;
                    out_illegal   <= 1'b0;
                end
            end
        end
    end

    // Counts delivered overflows; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && out_overflow && !(&ovf_count)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// alu_32: combinational 32-bit ALU driven by the 4-bit alu_control code.
//   a, b         operands
//   alu_control  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//   resultado    result (0 for unknown codes)
//   zero         resultado == 0
//   carry_out    bit 32 of the add/subtract; 1 on SUB means no borrow
//   overflow     signed overflow of ADD/SUB
module alu_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_control,
    output logic [31:0] resultado,
    output logic        zero,
    output logic        carry_out,
    output logic        overflow
);

    logic [32:0] add_full;
    logic [32:0] sub_full;

    // Subtraction is a + ~b + 1 so bit 32 is the inverted borrow.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + 33'd1;

    always_comb begin
        resultado = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (alu_control)
            4'b0000: resultado = a & b;
            4'b0001: resultado = a | b;
            4'b0010: begin
                resultado = add_full[31:0];
                carry_out = add_full[32];
                overflow  = (a[31] == b[31]) && (add_full[31] != a[31]);
            end
            4'b0110: begin
                resultado = sub_full[31:0];
                carry_out = sub_full[32];
                overflow  = (a[31] != b[31]) && (sub_full[31] != a[31]);
            end
            4'b0111: resultado = {31'd0, $signed(a) < $signed(b)};
            4'b1100: resultado = ~(a | b);
            default: resultado = '0;
        endcase
    end

    assign zero = (resultado == 32'd0);

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Self-checking bench for alu_issue_pipe: directed cases followed by a long
// randomized run, all scored against a reference model that works from the
// operation mnemonics with plain integer arithmetic.
module tb_alu_issue_pipe;

    localparam int OVF_W = 16;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_resultado;
    logic             out_zero;
    logic             out_carry_out;
    logic             out_overflow;
    logic             out_illegal;
    logic [OVF_W-1:0] ovf_count;

    int               n_cmp = 0;
    int               n_err = 0;
    exp_t             exp_q[$];
    exp_t             cur_exp;
    logic [OVF_W-1:0] ovf_m;
    bit               accepted;
    bit               stall_prev;
    logic [31:0]      prev_res;
    logic [3:0]       prev_flags;

    alu_issue_pipe #(.OVF_CNT_W(OVF_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_aluop      (in_aluop),
        .in_funct      (in_funct),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_resultado (out_resultado),
        .out_zero      (out_zero),
        .out_carry_out (out_carry_out),
        .out_overflow  (out_overflow),
        .out_illegal   (out_illegal),
        .ovf_count     (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic z, input logic c,
                                input logic v, input logic ill);
        exp_t e;
        e.res = res; e.z = z; e.c = c; e.v = v; e.ill = ill;
        return e;
    endfunction

    // Reference model: mnemonic decode, then 64-bit integer arithmetic.
    function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] funct,
                                   input logic [31:0] a, input logic [31:0] b);
        string       op;
        longint      sa;
        longint      sb;
        longint      s;
        longint      ua;
        longint      ub;
        logic [31:0] r;
        logic        c;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        c  = 1'b0;
        v  = 1'b0;
        if (aluop == 2'd0)      op = "add";
        else if (aluop == 2'd1) op = "sub";
        else if (aluop == 2'd3) op = "ill";
        else begin
            case (funct)
                6'h20:   op = "add";
                6'h22:   op = "sub";
                6'h24:   op = "and";
                6'h25:   op = "or";
                6'h27:   op = "nor";
                6'h2a:   op = "slt";
                default: op = "ill";
            endcase
        end
        if (op == "ill") return mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (op == "add") begin
            r = a + b;
            c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == "sub") begin
            r = a - b;
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == "and") r = a & b;
        else if (op == "or")      r = a | b;
        else if (op == "nor")     r = ~(a | b);
        else                      r = (sa < sb) ? 32'd1 : 32'd0;
        return mk(r, r == 32'd0, c, v, 1'b0);
    endfunction

    // One clock: check outputs at the falling edge, score handshakes, then
    // return 1 ns after the rising edge so the caller can drive new inputs.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (stall_prev) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_res", out_resultado, prev_res);
            chk("hold_flags", {28'd0, out_zero, out_carry_out, out_overflow, out_illegal},
                {28'd0, prev_flags});
        end
        stall_prev = out_valid && !out_ready;
        prev_res   = out_resultado;
        prev_flags = {out_zero, out_carry_out, out_overflow, out_illegal};
        chk("ovf_count", {16'd0, ovf_count}, {16'd0, ovf_m});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("res", out_resultado, e.res);
                chk("zero", {31'd0, out_zero}, {31'd0, e.z});
                chk("carry", {31'd0, out_carry_out}, {31'd0, e.c});
                chk("ovf", {31'd0, out_overflow}, {31'd0, e.v});
                chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                if (e.v && ovf_m != {OVF_W{1'b1}}) ovf_m = ovf_m + 1'b1;
            end
        end
        accepted = in_valid && in_ready && rst_n;
        if (accepted) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic send(input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit rand_bp);
        int n;
        in_aluop = aluop; in_funct = funct; in_a = a; in_b = b;
        cur_exp  = e;
        in_valid = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        if (!accepted) chk("accept_timeout", {31'd0, accepted}, 32'd1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  legal_funct[6];
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] ra;
        logic [31:0] rb;
        legal_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_aluop = 2'd0; in_funct = 6'd0; in_a = 32'd0; in_b = 32'd0;
        ovf_m = '0; stall_prev = 1'b0; accepted = 1'b0;
        prev_res = 32'd0; prev_flags = 4'd0; cur_exp = '0;

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res", out_resultado, 32'd0);
        chk("rst_flags", {28'd0, out_zero, out_carry_out, out_overflow, out_illegal}, 32'd0);
        chk("rst_ovf_count", {16'd0, ovf_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // 5 + 3 with latency check.
        send(2'b10, 6'b100000, 32'd5, 32'd3, mk(32'd8, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        in_valid = 1'b0;
        chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_res", out_resultado, 32'd8);
        step();

        // Back-to-back carry / overflow.
        send(2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        send(2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        drain();
        chk("ovf_after_b2b", {16'd0, ovf_count}, 32'd1);

        // Branch subtract and SLT.
        send(2'b01, 6'd0, 32'd20, 32'd30, mk(32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        send(2'b10, 6'b101010, 32'hFFFF_FFF6, 32'd5, mk(32'd1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        // Illegal encodings.
        send(2'b10, 6'b000000, 32'd9, 32'd9, mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
        send(2'b11, 6'b100000, 32'd9, 32'd9, mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
        drain();

        // Backpressure: two fill the pipe, the third is refused until release.
        out_ready = 1'b0;
        send(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        send(2'b10, 6'b100101, 32'h0000_000F, 32'h0000_00F0, mk(32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        in_aluop = 2'b10; in_funct = 6'b100111; in_a = 32'd0; in_b = 32'd0;
        cur_exp  = mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        step(); step(); step();
        chk("bp_queued", exp_q.size(), 32'd2);
        out_ready = 1'b1;
        send(2'b10, 6'b100111, 32'd0, 32'd0, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        drain();

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(2'b00, 6'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, model(2'b00, 6'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF), 1'b0);
        send(2'b00, 6'd0, 32'd1, 32'd2, mk(32'd3, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ovf_count", {16'd0, ovf_count}, 32'd0);
        exp_q.delete();
        ovf_m = '0;
        stall_prev = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(); step(); step();
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Randomized run.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_aluop = 2'($urandom); in_funct = 6'($urandom);
                in_a = $urandom; in_b = $urandom;
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            case ($urandom_range(0, 9))
                0, 1:    op = 2'b00;
                2, 3:    op = 2'b01;
                4:       op = 2'b11;
                default: op = 2'b10;
            endcase
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_funct[$urandom_range(0, 5)];
            ra = pick_operand();
            rb = pick_operand();
            send(op, fn, ra, rb, model(op, fn, ra, rb), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
